// File: rtl/mc_pkg.sv
// Shared opcode, ALU function and state definitions for the multi-cycle controller.
// Opcodes are instruction bits [6:2]; the low two bits are always 2'b11 in RV32I.
package mc_pkg;

    localparam logic [4:0] RType  = 5'b01100;
    localparam logic [4:0] IType  = 5'b00100;
    localparam logic [4:0] LType  = 5'b00000;
    localparam logic [4:0] SType  = 5'b01000;
    localparam logic [4:0] SBType = 5'b11000;
    localparam logic [4:0] UType  = 5'b01101;
    localparam logic [4:0] IJal   = 5'b11011;
    localparam logic [4:0] IJalr  = 5'b11001;
    localparam logic [4:0] ICsrr  = 5'b11100;

    // {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2
    } state_t;

    // Flags come from rs1 - rs2; Carry=1 means no borrow (rs1 >= rs2 unsigned).
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic neg, input logic carry);
        case (f3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return neg;
            3'b101:  return !neg;
            3'b110:  return !carry;
            3'b111:  return carry;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_if.sv
// Controller-facing bundle: instruction fetch, datapath control/flags, data memory and irq.
// The controller drives through master; the memories/datapath model sits on slave.
interface mc_if #(
    parameter int NBITS       = 8,
    parameter int NREGS       = 32,
    parameter int WIDTH_ALUF  = 4,
    parameter int NINSTR_BITS = 32
);
    localparam int RBITS = $clog2(NREGS);

    logic                    instr_req;
    logic [NBITS-1:0]        instr_addr;
    logic [NINSTR_BITS-1:0]  instruction;
    logic                    instr_valid;

    logic [RBITS-1:0]        RS1;
    logic [RBITS-1:0]        RS2;
    logic [RBITS-1:0]        RD;
    logic signed [NBITS-1:0] IMM;
    logic                    ALUSrc;
    logic [WIDTH_ALUF-1:0]   ALUControl;
    logic                    MemtoReg;
    logic                    RegWrite;
    logic                    link;
    logic [NBITS-1:0]        pclink;
    logic                    Zero;
    logic                    Neg;
    logic                    Carry;
    logic [NBITS-1:0]        PCReg;

    logic                    MemRead;
    logic                    MemWrite;
    logic                    busy;
    logic                    interrupt;

    modport master (
        output instr_req, instr_addr, RS1, RS2, RD, IMM, ALUSrc, ALUControl,
               MemtoReg, RegWrite, link, pclink, MemRead, MemWrite,
        input  instruction, instr_valid, Zero, Neg, Carry, PCReg, busy, interrupt
    );

    modport slave (
        input  instr_req, instr_addr, RS1, RS2, RD, IMM, ALUSrc, ALUControl,
               MemtoReg, RegWrite, link, pclink, MemRead, MemWrite,
        output instruction, instr_valid, Zero, Neg, Carry, PCReg, busy, interrupt
    );

endinterface

// File: rtl/mc_immgen.sv
// Immediate generator: selects I/S/B/U/J format from the opcode, purely combinational.
// Result is the 32-bit RV32I immediate sign-extended or truncated to NBITS.
module mc_immgen
    import mc_pkg::*;
#(
    parameter int NBITS       = 8,
    parameter int NINSTR_BITS = 32
) (
    input  logic [NINSTR_BITS-1:0] ir,
    output logic signed [NBITS-1:0] imm
);

    logic signed [31:0] imm32;
    logic               unused_lsb;

    assign unused_lsb = ^ir[1:0];

    always_comb begin
        case (ir[6:2])
            SType:   imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            SBType:  imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            UType:   imm32 = {ir[31:12], 12'b0};
            IJal:    imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm32 = {{20{ir[31]}}, ir[31:20]};
        endcase
        imm = NBITS'(imm32);
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I controller: FETCH -> EXEC [-> MEM] with maskable interrupt entry.
// 2 cycles min per ALU/branch/jump, 3 min per load/store; stalls on instr_valid=0 and busy=1.
module mc_controller
    import mc_pkg::*;
#(
    parameter int               NBITS       = 8,
    parameter int               NREGS       = 32,
    parameter int               WIDTH_ALUF  = 4,
    parameter int               NINSTR_BITS = 32,
    parameter logic [NBITS-1:0] RESET_PC    = '0,
    parameter logic [NBITS-1:0] IRQ_VECTOR  = NBITS'('h40)
) (
    input  logic             clock,
    input  logic             reset,
    mc_if.master             bus,
    output logic [NBITS-1:0] pc
);

    localparam int RBITS = $clog2(NREGS);

    state_t                 state_q, state_d;
    logic [NBITS-1:0]       pc_q, pc_d;
    logic [NBITS-1:0]       sepc_q, sepc_d;
    logic [NINSTR_BITS-1:0] ir_q, ir_d;
    logic                   ie_q, ie_d;

    logic signed [NBITS-1:0] imm;
    logic [4:0]              opcode;
    logic [2:0]              f3;
    logic                    f7b5;
    logic [NBITS-1:0]        pc_plus4;
    logic [NBITS-1:0]        pc_plus_imm;
    logic [NBITS-1:0]        next_pc;
    logic                    done;

    mc_immgen #(
        .NBITS       (NBITS),
        .NINSTR_BITS (NINSTR_BITS)
    ) u_immgen (
        .ir  (ir_q),
        .imm (imm)
    );

    assign opcode      = ir_q[6:2];
    assign f3          = ir_q[14:12];
    assign f7b5        = ir_q[30];
    assign pc_plus4    = pc_q + NBITS'(4);
    assign pc_plus_imm = pc_q + $unsigned(imm);
    assign pc          = pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            sepc_q  <= '0;
            ie_q    <= 1'b1;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sepc_q  <= sepc_d;
            ie_q    <= ie_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sepc_d  = sepc_q;
        ie_d    = ie_q;
        ir_d    = ir_q;
        next_pc = pc_plus4;
        done    = 1'b0;

        bus.instr_req  = 1'b0;
        bus.instr_addr = pc_q;
        bus.RS1        = '0;
        bus.RS2        = '0;
        bus.RD         = '0;
        bus.IMM        = '0;
        bus.ALUSrc     = 1'b0;
        bus.ALUControl = '0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.link       = 1'b0;
        bus.pclink     = pc_plus4;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;

        // Decode fields stay visible for the whole of EXEC and MEM.
        if (state_q != FETCH) begin
            bus.RS1 = RBITS'(ir_q[19:15]);
            bus.RS2 = RBITS'(ir_q[24:20]);
            bus.RD  = RBITS'(ir_q[11:7]);
            bus.IMM = imm;
        end

        case (state_q)
            FETCH: begin
                bus.instr_req = 1'b1;
                if (bus.instr_valid) begin
                    ir_d    = bus.instruction;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                done    = 1'b1;
                state_d = FETCH;
                case (opcode)
                    RType: begin
                        bus.ALUControl = WIDTH_ALUF'({f7b5, f3});
                        bus.RegWrite   = 1'b1;
                    end
                    IType: begin
                        bus.ALUSrc     = 1'b1;
                        bus.ALUControl = (f3 == 3'b101) ? WIDTH_ALUF'({f7b5, f3})
                                                        : WIDTH_ALUF'({1'b0, f3});
                        bus.RegWrite   = 1'b1;
                    end
                    UType: begin
                        bus.ALUSrc     = 1'b1;
                        bus.RS1        = '0;
                        bus.ALUControl = WIDTH_ALUF'(ALU_ADD);
                        bus.RegWrite   = 1'b1;
                    end
                    SBType: begin
                        bus.ALUControl = WIDTH_ALUF'(ALU_SUB);
                        if (branch_taken(f3, bus.Zero, bus.Neg, bus.Carry))
                            next_pc = pc_plus_imm;
                    end
                    IJal: begin
                        bus.link     = 1'b1;
                        bus.RegWrite = 1'b1;
                        next_pc      = pc_plus_imm;
                    end
                    IJalr: begin
                        bus.ALUSrc     = 1'b1;
                        bus.ALUControl = WIDTH_ALUF'(ALU_ADD);
                        bus.link       = 1'b1;
                        bus.RegWrite   = 1'b1;
                        next_pc        = {bus.PCReg[NBITS-1:1], 1'b0};
                    end
                    ICsrr: begin
                        bus.link     = 1'b1;
                        bus.pclink   = sepc_q;
                        bus.RegWrite = 1'b1;
                        ie_d         = 1'b1;
                    end
                    LType, SType: begin
                        bus.ALUSrc     = 1'b1;
                        bus.ALUControl = WIDTH_ALUF'(ALU_ADD);
                        done           = 1'b0;
                        state_d        = MEM;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                bus.ALUSrc     = 1'b1;
                bus.ALUControl = WIDTH_ALUF'(ALU_ADD);
                bus.MemRead    = (opcode == LType);
                bus.MemWrite   = (opcode == SType);
                if (!bus.busy) begin
                    done    = 1'b1;
                    state_d = FETCH;
                    if (opcode == LType) begin
                        bus.MemtoReg = 1'b1;
                        bus.RegWrite = 1'b1;
                    end
                end
            end
            default: state_d = FETCH;
        endcase

        // The completing instruction commits; only the PC is redirected.
        if (done) begin
            pc_d = next_pc;
            if (bus.interrupt && ie_q) begin
                sepc_d = next_pc;
                pc_d   = IRQ_VECTOR;
                ie_d   = 1'b0;
            end
        end

        if (reset) begin
            bus.instr_req  = 1'b0;
            bus.RS1        = '0;
            bus.RS2        = '0;
            bus.RD         = '0;
            bus.IMM        = '0;
            bus.ALUSrc     = 1'b0;
            bus.ALUControl = '0;
            bus.MemtoReg   = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.link       = 1'b0;
            bus.pclink     = '0;
            bus.MemRead    = 1'b0;
            bus.MemWrite   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed-vector bench for mc_controller: each instruction is fetched with a
// hand-picked PC, flags and busy pattern, and outputs are compared against fixed values.
module tb_mc_controller;

    logic       clock;
    logic       reset;
    logic [7:0] pc;
    int         n_cmp;
    int         n_err;
    int         mr_cycles;

    mc_if #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4), .NINSTR_BITS(32)) bus ();

    mc_controller #(
        .NBITS       (8),
        .NREGS       (32),
        .WIDTH_ALUF  (4),
        .NINSTR_BITS (32),
        .RESET_PC    (8'h00),
        .IRQ_VECTOR  (8'h40)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master),
        .pc    (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_ins(input logic [11:0] imm, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_ins(input logic [12:0] imm, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_ins(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Entered at a falling edge while in FETCH; returns #1 into the EXEC cycle.
    task automatic do_fetch(input logic [31:0] ins, input logic [7:0] exp_pc, input int lat);
        check("fetch_pc", {24'b0, bus.instr_addr}, {24'b0, exp_pc});
        check("fetch_req", {31'b0, bus.instr_req}, 32'd1);
        for (int i = 0; i < lat; i++) begin
            bus.instr_valid = 1'b0;
            tick();
            #1;
            check("fetch_wait_req", {31'b0, bus.instr_req}, 32'd1);
        end
        bus.instruction = ins;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        reset           = 1'b1;
        bus.instruction = '0;
        bus.instr_valid = 1'b0;
        bus.Zero        = 1'b0;
        bus.Neg         = 1'b0;
        bus.Carry       = 1'b0;
        bus.PCReg       = '0;
        bus.busy        = 1'b0;
        bus.interrupt   = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        check("rst_req", {31'b0, bus.instr_req}, 32'd0);
        check("rst_regwrite", {31'b0, bus.RegWrite}, 32'd0);
        check("rst_mem", {30'b0, bus.MemRead, bus.MemWrite}, 32'd0);
        check("rst_link_m2r", {30'b0, bus.link, bus.MemtoReg}, 32'd0);
        check("rst_decode", {20'b0, bus.RS1, bus.ALUControl, bus.ALUSrc, 2'b0}, 32'd0);
        check("rst_imm", {24'b0, $unsigned(bus.IMM)}, 32'd0);
        check("rst_pc", {24'b0, pc}, 32'd0);
        reset = 1'b0;
        #1;

        // ADDI x1,x0,5 at pc=0
        do_fetch(i_ins(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 8'h00, 0);
        check("addi_rd", {27'b0, bus.RD}, 32'd1);
        check("addi_imm", {24'b0, $unsigned(bus.IMM)}, 32'd5);
        check("addi_alusrc", {31'b0, bus.ALUSrc}, 32'd1);
        check("addi_aluc", {28'b0, bus.ALUControl}, 32'd0);
        check("addi_regwrite", {31'b0, bus.RegWrite}, 32'd1);
        tick();
        #1;
        check("addi_pc", {24'b0, pc}, 32'd4);
        check("addi_regwrite_drop", {31'b0, bus.RegWrite}, 32'd0);

        // SLT x3,x1,x2 at pc=4
        do_fetch(r_ins(7'd0, 5'd2, 5'd1, 3'b010, 5'd3), 8'h04, 0);
        check("slt_aluc", {28'b0, bus.ALUControl}, 32'b0010);
        check("slt_alusrc", {31'b0, bus.ALUSrc}, 32'd0);
        check("slt_regs", {17'b0, bus.RS1, bus.RS2, bus.RD}, {17'b0, 5'd1, 5'd2, 5'd3});
        tick();
        #1;

        // BNE x1,x2,-8 at pc=8 with Zero=0: taken, wraps to 0
        bus.Zero = 1'b0;
        do_fetch(b_ins(13'h1FF8, 5'd2, 5'd1, 3'b001), 8'h08, 0);
        check("bne_aluc", {28'b0, bus.ALUControl}, 32'b1000);
        check("bne_imm", {24'b0, $unsigned(bus.IMM)}, 32'hF8);
        check("bne_regwrite", {31'b0, bus.RegWrite}, 32'd0);
        tick();
        #1;
        check("bne_taken_pc", {24'b0, pc}, 32'd0);

        // BLTU x0,x0,+8 at pc=0 with Carry=0: taken
        bus.Carry = 1'b0;
        do_fetch(b_ins(13'd8, 5'd0, 5'd0, 3'b110), 8'h00, 0);
        tick();
        #1;
        check("bltu_taken_pc", {24'b0, pc}, 32'd8);

        // BNE again at pc=8 with Zero=1: not taken
        bus.Zero = 1'b1;
        do_fetch(b_ins(13'h1FF8, 5'd2, 5'd1, 3'b001), 8'h08, 0);
        tick();
        #1;
        check("bne_fall_pc", {24'b0, pc}, 32'd12);
        bus.Zero = 1'b0;

        // LW x4,4(x1) at pc=12 with busy high for 3 cycles
        do_fetch(i_ins(12'd4, 5'd1, 3'b010, 5'd4, 7'b0000011), 8'h0C, 0);
        check("lw_exec_strobes", {29'b0, bus.MemRead, bus.RegWrite, bus.MemtoReg}, 32'd0);
        check("lw_imm", {24'b0, $unsigned(bus.IMM)}, 32'd4);
        tick();
        mr_cycles = 0;
        bus.busy  = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (bus.MemRead) mr_cycles++;
            check("lw_busy_wb", {30'b0, bus.RegWrite, bus.MemtoReg}, 32'd0);
            check("lw_busy_alu", {27'b0, bus.ALUSrc, bus.ALUControl}, 32'b10000);
            tick();
            #1;
        end
        bus.busy = 1'b0;
        #1;
        if (bus.MemRead) mr_cycles++;
        check("lw_done_wb", {30'b0, bus.RegWrite, bus.MemtoReg}, 32'b11);
        check("lw_done_rd", {27'b0, bus.RD}, 32'd4);
        tick();
        #1;
        check("lw_memread_cycles", mr_cycles, 32'd4);
        check("lw_pc", {24'b0, pc}, 32'd16);
        check("lw_memread_drop", {31'b0, bus.MemRead}, 32'd0);

        // SRAI x6,x6,2 at pc=16
        do_fetch(i_ins({7'b0100000, 5'd2}, 5'd6, 3'b101, 5'd6, 7'b0010011), 8'h10, 0);
        check("srai_aluc", {28'b0, bus.ALUControl}, 32'b1101);
        tick();
        #1;

        // JAL x1,+16 at pc=20
        do_fetch(j_ins(21'd16, 5'd1), 8'h14, 0);
        check("jal_link", {30'b0, bus.link, bus.RegWrite}, 32'b11);
        check("jal_pclink", {24'b0, bus.pclink}, 32'd24);
        check("jal_imm", {24'b0, $unsigned(bus.IMM)}, 32'd16);
        tick();
        #1;
        check("jal_pc", {24'b0, pc}, 32'd36);

        // JALR x0,0(x1) at pc=36 with PCReg=25
        bus.PCReg = 8'd25;
        do_fetch(i_ins(12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111), 8'h24, 0);
        check("jalr_ctl", {26'b0, bus.link, bus.RegWrite, bus.ALUSrc, bus.ALUControl[2:0]},
              32'b111000);
        check("jalr_pclink", {24'b0, bus.pclink}, 32'd40);
        tick();
        #1;
        check("jalr_pc", {24'b0, pc}, 32'd24);

        // SW x2,0(x1) at pc=24, interrupt raised while busy
        do_fetch(s_ins(12'd0, 5'd2, 5'd1, 3'b010), 8'h18, 0);
        tick();
        bus.busy      = 1'b1;
        bus.interrupt = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("sw_busy_write", {30'b0, bus.MemWrite, bus.MemRead}, 32'b10);
            tick();
            #1;
        end
        bus.busy = 1'b0;
        #1;
        check("sw_done_write", {30'b0, bus.MemWrite, bus.RegWrite}, 32'b10);
        tick();
        #1;
        check("irq_vector_pc", {24'b0, pc}, 32'h40);

        // Interrupt still high but ie=0: ignored
        do_fetch(i_ins(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011), 8'h40, 0);
        tick();
        #1;
        check("irq_masked_pc", {24'b0, pc}, 32'h44);

        // CSRR x5 returns sepc=28 and re-enables; ie was still 0 at completion
        do_fetch(i_ins(12'h141, 5'd0, 3'b010, 5'd5, 7'b1110011), 8'h44, 0);
        check("csrr_pclink", {24'b0, bus.pclink}, 32'd28);
        check("csrr_ctl", {25'b0, bus.link, bus.RegWrite, bus.RD}, {25'b0, 2'b11, 5'd5});
        tick();
        #1;
        check("csrr_pc", {24'b0, pc}, 32'h48);

        // Now enabled: ADDI at 0x48 completes then traps with sepc=0x4C
        do_fetch(i_ins(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011), 8'h48, 0);
        check("irq2_commit", {31'b0, bus.RegWrite}, 32'd1);
        tick();
        #1;
        check("irq2_pc", {24'b0, pc}, 32'h40);
        bus.interrupt = 1'b0;

        do_fetch(i_ins(12'h141, 5'd0, 3'b010, 5'd6, 7'b1110011), 8'h40, 0);
        check("csrr2_pclink", {24'b0, bus.pclink}, 32'h4C);
        tick();
        #1;

        // Unknown opcode behaves as NOP, fetched with two wait cycles
        do_fetch(32'h0000007F, 8'h44, 2);
        check("nop_strobes", {28'b0, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.link}, 32'd0);
        tick();
        #1;
        check("nop_pc", {24'b0, pc}, 32'h48);

        // Reset while a store is stalled in MEM
        do_fetch(s_ins(12'd0, 5'd2, 5'd1, 3'b010), 8'h48, 0);
        tick();
        bus.busy = 1'b1;
        #1;
        check("sw2_busy_write", {31'b0, bus.MemWrite}, 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check("rst_mem_write", {31'b0, bus.MemWrite}, 32'd0);
        check("rst_mem_req", {31'b0, bus.instr_req}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_mem_pc", {24'b0, pc}, 32'd0);
        check("rst_mem_fetch", {30'b0, bus.instr_req, bus.MemWrite}, 32'b10);
        bus.busy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
